// File: rtl/wb_arbiter.sv
// wb_arbiter: merges pipeline and buffered long-latency results onto one register file write port (optional WB_TRACE_EN trace output)
module wb_arbiter #(
  parameter int FIFO_DEPTH   = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pipe_we,
  input  logic [4:0]  pipe_sel,
  input  logic [31:0] pipe_data,
  input  logic        lu_valid,
  input  logic [4:0]  lu_sel,
  input  logic [31:0] lu_data,
  output logic        lu_ready,
  output logic        pipe_stall,
  input  logic [4:0]  rd_sel,
  output logic        pend_hit,
  output logic        gpr_we,
  output logic [4:0]  gpr_sel,
  output logic [31:0] gpr_data
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(STARVE_LIMIT + 1);
  logic [AW:0]           wp, rp;
  logic [4:0]            q_sel  [FIFO_DEPTH];
  logic [31:0]           q_data [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] vld;
  logic [CW-1:0]         cnt;
  logic                  full, empty, pipe_go, pop, push;
  assign empty      = wp == rp;
  assign full       = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  assign lu_ready   = !full;
  assign pipe_stall = (cnt >= CW'(STARVE_LIMIT)) && !empty;
  assign pipe_go    = !pipe_stall && pipe_we && pipe_sel != '0;
  assign pop        = !pipe_go && !empty;
  assign push       = lu_valid && !full && lu_sel != '0;
  // pointers, per-slot valid bits and starvation counter; counter only grows while the pipeline blocks a non-empty FIFO
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wp  <= '0;
      rp  <= '0;
      vld <= '0;
      cnt <= '0;
    end else begin
      wp  <= push ? wp + 1'b1 : wp;
      rp  <= pop ? rp + 1'b1 : rp;
      cnt <= (pipe_go && !empty) ? cnt + 1'b1 : '0;
      if (pop) vld[rp[AW-1:0]] <= 1'b0;
      if (push) vld[wp[AW-1:0]] <= 1'b1;
    end
  // FIFO storage needs no reset; the valid bits and pointers gate it
  always_ff @(posedge clk)
    if (push) begin
      q_sel[wp[AW-1:0]]  <= lu_sel;
      q_data[wp[AW-1:0]] <= lu_data;
    end
  // registered write port: the grant of this cycle is presented for exactly one cycle next cycle
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      gpr_we   <= 1'b0;
      gpr_sel  <= '0;
      gpr_data <= '0;
    end else begin
      gpr_we   <= pipe_go || pop;
      gpr_sel  <= pipe_go ? pipe_sel : pop ? q_sel[rp[AW-1:0]] : '0;
      gpr_data <= pipe_go ? pipe_data : pop ? q_data[rp[AW-1:0]] : '0;
    end
  // pending hit over buffered entries, including one being popped this cycle
  always_comb begin
    pend_hit = 1'b0;
    for (int i = 0; i < FIFO_DEPTH; i++) pend_hit = pend_hit || (vld[i] && q_sel[i] == rd_sel);
    pend_hit = pend_hit && rd_sel != '0;
  end
`ifdef WB_TRACE_EN
  logic src_l;
  // remembers which source produced the write now on gpr_*
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) src_l <= 1'b0;
    else src_l <= pop;
  // write and drain trace
  always_ff @(posedge clk) begin
    if (rst_n && gpr_we) $display("[WB] src=%s R[%0d] = %h", src_l ? "L" : "P", gpr_sel, gpr_data);
    if (rst_n && pipe_stall) $display("[WB] starve drain");
  end
`endif
endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter: table-driven and sequence checks for wb_arbiter
module tb_wb_arbiter;
  logic        clk, rst_n;
  logic        pipe_we, lu_valid;
  logic [4:0]  pipe_sel, lu_sel, rd_sel;
  logic [31:0] pipe_data, lu_data;
  logic        lu_ready, pipe_stall, pend_hit, gpr_we;
  logic [4:0]  gpr_sel;
  logic [31:0] gpr_data;
  int tests = 0;
  int fails = 0;
  typedef struct {
    logic        pw;
    logic [4:0]  ps;
    logic [31:0] pd;
    logic        lv;
    logic [4:0]  ls;
    logic [31:0] ld;
    logic [4:0]  rs;
    logic        lr, st, ph, we;
    logic [4:0]  gs;
    logic [31:0] gd;
  } vec_t;
  vec_t v[64];
  int n = 0;
  wb_arbiter #(.FIFO_DEPTH(2), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .pipe_we(pipe_we), .pipe_sel(pipe_sel), .pipe_data(pipe_data),
    .lu_valid(lu_valid), .lu_sel(lu_sel), .lu_data(lu_data),
    .lu_ready(lu_ready), .pipe_stall(pipe_stall),
    .rd_sel(rd_sel), .pend_hit(pend_hit),
    .gpr_we(gpr_we), .gpr_sel(gpr_sel), .gpr_data(gpr_data)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic add(input logic pw, input logic [4:0] ps, input logic [31:0] pd,
                     input logic lv, input logic [4:0] ls, input logic [31:0] ld, input logic [4:0] rs,
                     input logic lr, input logic st, input logic ph, input logic we,
                     input logic [4:0] gs, input logic [31:0] gd);
    v[n] = '{pw, ps, pd, lv, ls, ld, rs, lr, st, ph, we, gs, gd};
    n++;
  endtask
  task automatic idle();
    pipe_we = 0; pipe_sel = 0; pipe_data = 0; lu_valid = 0; lu_sel = 0; lu_data = 0; rd_sel = 0;
  endtask
  initial begin
    logic [31:0] q[$];
    int k, got;
    logic [4:0] s;
    //  pw ps  pd            lv ls  ld            rs   lr st ph we gs  gd
    add(1, 5,  32'h1234ABCD, 0, 0,  0,            0,   1, 0, 0, 0, 0,  0);
    add(0, 0,  0,            0, 0,  0,            0,   1, 0, 0, 1, 5,  32'h1234ABCD);
    add(0, 0,  0,            0, 0,  0,            0,   1, 0, 0, 0, 0,  0);
    add(0, 0,  0,            1, 9,  32'hDEADBEEF, 9,   1, 0, 0, 0, 0,  0);
    add(0, 0,  0,            0, 0,  0,            9,   1, 0, 1, 0, 0,  0);
    add(0, 0,  0,            0, 0,  0,            9,   1, 0, 0, 1, 9,  32'hDEADBEEF);
    add(0, 0,  0,            0, 0,  0,            9,   1, 0, 0, 0, 0,  0);
    add(1, 7,  32'hA0,       1, 3,  32'h33333333, 3,   1, 0, 0, 0, 0,  0);
    add(1, 7,  32'hA1,       1, 4,  32'h44444444, 4,   1, 0, 0, 1, 7,  32'hA0);
    add(1, 7,  32'hA2,       0, 0,  0,            4,   0, 0, 1, 1, 7,  32'hA1);
    add(1, 7,  32'hA3,       0, 0,  0,            3,   0, 0, 1, 1, 7,  32'hA2);
    add(1, 7,  32'hA4,       0, 0,  0,            0,   0, 0, 0, 1, 7,  32'hA3);
    add(1, 7,  32'hA5,       0, 0,  0,            3,   0, 1, 1, 1, 7,  32'hA4);
    add(1, 7,  32'hA6,       0, 0,  0,            3,   1, 0, 0, 1, 3,  32'h33333333);
    add(1, 7,  32'hA7,       0, 0,  0,            4,   1, 0, 1, 1, 7,  32'hA6);
    add(1, 7,  32'hA8,       0, 0,  0,            4,   1, 0, 1, 1, 7,  32'hA7);
    add(1, 7,  32'hA9,       0, 0,  0,            4,   1, 0, 1, 1, 7,  32'hA8);
    add(1, 7,  32'hAA,       0, 0,  0,            4,   1, 1, 1, 1, 7,  32'hA9);
    add(0, 0,  0,            0, 0,  0,            4,   1, 0, 0, 1, 4,  32'h44444444);
    add(0, 0,  0,            0, 0,  0,            4,   1, 0, 0, 0, 0,  0);
    add(1, 0,  32'hFFFF,     1, 0,  32'h1,        0,   1, 0, 0, 0, 0,  0);
    add(1, 0,  32'hFFFF,     1, 0,  32'h2,        0,   1, 0, 0, 0, 0,  0);
    add(0, 0,  0,            0, 0,  0,            0,   1, 0, 0, 0, 0,  0);
    add(0, 0,  0,            0, 0,  0,            0,   1, 0, 0, 0, 0,  0);
    idle();
    rst_n = 0;
    #1;
    chk("reset gpr_we", 32'(gpr_we), 0);
    chk("reset gpr_sel", 32'(gpr_sel), 0);
    chk("reset gpr_data", gpr_data, 0);
    chk("reset pipe_stall", 32'(pipe_stall), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1;
    #1;
    chk("reset lu_ready", 32'(lu_ready), 1);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      pipe_we = v[i].pw; pipe_sel = v[i].ps; pipe_data = v[i].pd;
      lu_valid = v[i].lv; lu_sel = v[i].ls; lu_data = v[i].ld; rd_sel = v[i].rs;
      #1;
      chk($sformatf("row%0d lu_ready", i), 32'(lu_ready), 32'(v[i].lr));
      chk($sformatf("row%0d pipe_stall", i), 32'(pipe_stall), 32'(v[i].st));
      chk($sformatf("row%0d pend_hit", i), 32'(pend_hit), 32'(v[i].ph));
      chk($sformatf("row%0d gpr_we", i), 32'(gpr_we), 32'(v[i].we));
      if (v[i].we) begin
        chk($sformatf("row%0d gpr_sel", i), 32'(gpr_sel), 32'(v[i].gs));
        chk($sformatf("row%0d gpr_data", i), gpr_data, v[i].gd);
      end
    end
    @(negedge clk);
    pipe_we = 1; pipe_sel = 7; pipe_data = 32'h77; lu_valid = 1; lu_sel = 10; lu_data = 32'hA;
    @(negedge clk);
    lu_sel = 11; lu_data = 32'hB;
    @(negedge clk);
    lu_valid = 0; rd_sel = 11;
    #1;
    chk("mid pend_hit before reset", 32'(pend_hit), 1);
    chk("mid gpr_we before reset", 32'(gpr_we), 1);
    rst_n = 0;
    #1;
    chk("mid reset gpr_we", 32'(gpr_we), 0);
    chk("mid reset pend_hit", 32'(pend_hit), 0);
    chk("mid reset lu_ready", 32'(lu_ready), 1);
    idle();
    @(negedge clk);
    rst_n = 1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      rd_sel = i[0] ? 5'd11 : 5'd10;
      #1;
      chk($sformatf("post reset c%0d gpr_we", i), 32'(gpr_we), 0);
      chk($sformatf("post reset c%0d pend_hit", i), 32'(pend_hit), 0);
      chk($sformatf("post reset c%0d lu_ready", i), 32'(lu_ready), 1);
    end
    k = 0;
    got = 0;
    for (int r = 0; r < 11; r++)
      for (int c = 0; c < 5; c++) begin
        @(negedge clk);
        s = 5'(k % 31 + 1);
        pipe_we = r < 10 && c < 2; pipe_sel = 31; pipe_data = 32'hF0000000;
        lu_valid = r < 10 && c < 2; lu_sel = s; lu_data = 32'h50000000 | (32'(k) << 8) | 32'(s);
        #1;
        if (gpr_we && gpr_data[31:28] == 4'h5) begin
          got++;
          chk("wrap order", gpr_data, q.size() > 0 ? q.pop_front() : 32'hFFFFFFFF);
          chk("wrap sel", 32'(gpr_sel), 32'(gpr_data[4:0]));
        end
        if (lu_valid && lu_ready) begin
          q.push_back(lu_data);
          k++;
        end
      end
    chk("wrap pushes", k, 20);
    chk("wrap writes", got, 20);
    chk("wrap leftover", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/wb_arbiter.md
Name: wb_arbiter

Overview:
- Write-back arbiter that sits directly upstream of the register file write port (WE/WeSel/WData).
- Merges two write sources into the single write port:
  - in-order pipeline WB results;
  - out-of-order results from long-latency units (mul/div), buffered in a small FIFO.
- The pipeline has priority. A starvation guard stalls the pipeline so buffered results drain.
- Also reports pending-write hits, so the hazard unit can interlock readers.

Parameters:
- FIFO_DEPTH, 2, long-latency result buffer entries; power of 2, >=2.
- STARVE_LIMIT, 4, consecutive cycles a non-empty FIFO may wait unserved before pipe_stall asserts; >=1.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- pipe_we  input  1  pipeline write request this cycle
- pipe_sel  input  5  pipeline destination register
- pipe_data  input  32  pipeline write data
- lu_valid  input  1  long-latency result valid
- lu_sel  input  5  long-latency destination register
- lu_data  input  32  long-latency result data
- lu_ready  output  1  FIFO can accept (= !full); transfer when lu_valid && lu_ready
- pipe_stall  output  1  upstream must hold its WB stage this cycle
- rd_sel  input  5  register being read by ID stage
- pend_hit  output  1  a valid FIFO entry targets rd_sel (rd_sel != 0)
- gpr_we  output  1  to register file WE
- gpr_sel  output  5  to register file WeSel
- gpr_data  output  32  to register file WData

Behaviour:
- Reset (async, rst_n=0):
  - FIFO emptied; starvation counter = 0.
  - gpr_we=0, gpr_sel=0, gpr_data=0, pipe_stall=0.
  - lu_ready=1 once reset releases.
  - Reset mid-operation discards all buffered entries, with no write issued.
- gpr_we/gpr_sel/gpr_data are registered: a write granted in cycle N appears on gpr_* in cycle N+1, for exactly one cycle.
- Writes to register 0 are never issued:
  - pipe_we with pipe_sel=0 counts as no request.
  - A long-latency handshake with lu_sel=0 completes (lu_ready honoured) but the entry is discarded, not pushed.
- Grant rule, evaluated each cycle:
  - If pipe_stall=0 and pipe_we=1 and pipe_sel!=0: grant pipeline. FIFO holds and counter increments if FIFO is non-empty.
  - Else if FIFO is non-empty: pop head, grant it, counter := 0.
  - Else: no write (gpr_we=0 next cycle), counter := 0.
- Starvation guard:
  - pipe_stall = (counter >= STARVE_LIMIT) && FIFO non-empty. This is combinational from registered state.
  - While pipe_stall=1, pipe_we is ignored (upstream holds it) and the FIFO head is granted.
  - The counter clears on that pop, so pipe_stall is high for exactly one cycle per drain event.
- FIFO:
  - Circular read/write pointers with an extra wrap bit.
  - full/empty are derived from the pointers.
  - Push and pop in the same cycle are allowed when neither full nor empty.
  - lu_ready = !full, even if a pop occurs that cycle (no same-cycle pass-through when full).
- Ordering:
  - FIFO entries retire in push order.
  - A long-latency result is never bypassed straight to gpr_* in its push cycle; minimum push-to-write latency is 2 cycles.
- pend_hit is combinational OR over valid entries of (entry_sel == rd_sel), forced 0 when rd_sel=0.
  - An entry popped in cycle N still counts in cycle N.
  - pend_hit does not cover the entry on gpr_* in cycle N+1, because the register file write is already in flight.

Optional Feature:
- WB_TRACE_EN.
- Defined: on every cycle with gpr_we=1, $display "[WB] src=<P|L> R[<sel>] = <data hex>", where P marks pipeline and L marks long-latency; also display "[WB] starve drain" each cycle pipe_stall=1.
- Undefined: no simulation output; RTL and timing are identical otherwise.

Test Plan:
- Reset, then pipe_we=1 sel=5 data=0x1234ABCD for 1 cycle -> next cycle gpr_we=1, gpr_sel=5, gpr_data=0x1234ABCD; the cycle after, gpr_we=0.
- lu_valid push sel=9 data=0xDEADBEEF with pipe idle -> pend_hit=1 for rd_sel=9 for one cycle; gpr_* shows R9=0xDEADBEEF 2 cycles after the push; pend_hit then 0.
- Push 2 lu entries (sel=3, sel=4) while pipe_we=1 every cycle (sel=7) -> lu_ready=0 when full; pipe_stall=1 after STARVE_LIMIT=4 blocked cycles; R3 written, then after 4 more pipe-only cycles R4.
- pipe_we=1 sel=0 and lu push sel=0 -> gpr_we never asserts; lu_ready unaffected; FIFO stays empty.
- Two entries buffered, assert rst_n=0 mid-stream -> gpr_we=0 immediately; after release pend_hit=0, lu_ready=1, no stale writes ever appear.
- Fill/drain the FIFO 10 times with sequential sel 1..31 -> write order equals push order across pointer wrap-around.
